sig_deb_bank: RTL and testbench
===============================

Name: sig_deb_bank

Overview:
Multi-channel, parametrised debouncer. It conditions CHANNELS asynchronous inputs (buttons, switches, jumpers) into clean, synchronous levels, with per-channel rise/fall strobes. Debouncing is symmetric: both assertion and release are filtered. All channels share one sample-tick prescaler. Sits between board pins and control logic in place of per-signal single-edge debouncers.

Parameters:
CHANNELS, 8, number of independent input channels (>=1)
CLKS_PER_SMPL, 16, prescaler width; one sample tick every 2^CLKS_PER_SMPL clocks (>=1)
SMPL_CNT, 4, consecutive differing samples required before the output changes (>=1)
RST_VAL, 0, reset/initial level of every channel output and synchroniser (0 or 1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
i_sig  input  CHANNELS  raw asynchronous inputs
o_sig  output  CHANNELS  debounced levels, registered
o_rise  output  CHANNELS  1-clk strobe when o_sig[k] goes 0->1
o_fall  output  CHANNELS  1-clk strobe when o_sig[k] goes 1->0
o_chg  output  1  registered OR of all o_rise|o_fall bits; asserted in the same cycle as the strobes

Behaviour:
- One clock (clk). Reset is synchronous, active-low: sampled on the clk rising edge while rst_n=0.
- Reset values: sync flops=RST_VAL; prescaler=0; per-channel counters=0; o_sig={CHANNELS{RST_VAL}}; o_rise=o_fall=0; o_chg=0.
- Synchroniser: each channel has a 2-flop sync; sig_s[k]=sync stage 2.
- Prescaler: a free-running CLKS_PER_SMPL-bit up-counter. It is never reset by input activity and wraps naturally. tck=1 for one clk when the prescaler is all ones.
- Per channel k: counter cnt_k, width $clog2(SMPL_CNT) (minimum 1 bit). Per cycle, in priority order:
  1. sig_s[k]==o_sig[k]: cnt_k<=0, whatever tck is. Any agreeing cycle, even between ticks, restarts the count.
  2. tck && cnt_k==SMPL_CNT-1: o_sig[k]<=sig_s[k]; cnt_k<=0; o_rise[k] or o_fall[k]<=1 for the next cycle only.
  3. tck: cnt_k<=cnt_k+1.
  4. Otherwise: hold.
- Strobes are registered and aligned with the o_sig[k] change: the cycle o_sig changes, the matching strobe is 1. Strobes are never 1 for two consecutive cycles.
- Latency from a clean input step to o_sig: 2 sync clocks + time to the next tck + (SMPL_CNT-1)*2^CLKS_PER_SMPL clocks + 1. Worst case is 3 + SMPL_CNT*2^CLKS_PER_SMPL clocks.
- SMPL_CNT=1: output follows on the first tck that sees a mismatch.
- Channels are fully independent. Simultaneous rise on one channel and fall on another gives both strobes in the same cycle, and o_chg=1 once.
- Reset mid-count discards partial counts; no strobe is produced by reset or by reset release.
- Counter never exceeds SMPL_CNT-1; no wrap of cnt_k is possible.

Optional Feature:
SIG_DEB_EDGE_EN
- Defined: o_rise, o_fall and o_chg are generated as described.
- Undefined: the edge-strobe registers are not built; o_rise, o_fall and o_chg are tied to 0. The port list is unchanged, and o_sig behaviour is identical.

Decomposition:
- Package sig_deb_pkg: localparam helper for counter width (clog2 with min 1); default parameter constants; a typedef for the channel counter when used from SystemVerilog benches.
- Sub-module sig_deb_chan: one instance per channel via generate. It contains the 2-flop sync, cnt_k, the o_sig bit and its edge strobes. It takes tck, clk and rst_n as inputs.
- The top level owns the shared prescaler and the o_chg reduction.

Test Plan:
All scenarios use CHANNELS=4, CLKS_PER_SMPL=2 (tick every 4 clocks), SMPL_CNT=3, RST_VAL=0, SIG_DEB_EDGE_EN defined.
1. Reset with i_sig=4'hF held 10 clks, then release -> during reset o_sig=0 and no strobes. After release, o_sig=4'hF within 15 clks, with a single-cycle o_rise=4'hF and o_chg=1 in the same cycle.
2. Glitch: i_sig[0]=1 for 5 clks, then 0 -> o_sig[0] stays 0; o_rise, o_fall and o_chg stay 0 throughout.
3. Release debounce: from o_sig[2]=1, drop i_sig[2] to 0 stably -> o_sig[2]=0 after 3 ticks; o_fall[2] pulses for exactly 1 clk; other channels are unchanged.
4. Simultaneous events: i_sig[1] 0->1 and i_sig[3] 1->0 in the same clk -> o_rise[1] and o_fall[3] in the same cycle; o_chg high 1 clk.
5. Reset mid-count: rise i_sig[0], assert rst_n=0 after 2 ticks for 1 clk -> o_sig[0] is still 0. After release it needs a full 3 ticks to go high.
6. Chatter: i_sig[0] toggles every 3 clks for 40 clks, then holds 1 -> exactly one o_rise[0] strobe total and no o_fall[0]. Repeat with the macro undefined: o_rise, o_fall and o_chg stay 0 while o_sig matches.

Source files
------------

// File: rtl/sig_deb_pkg.sv
// Shared constants and helpers for the sig_deb_bank debouncer.
// Optional edge strobes are enabled by defining SIG_DEB_EDGE_EN.
package sig_deb_pkg;

  localparam int DEF_CHANNELS      = 8;
  localparam int DEF_CLKS_PER_SMPL = 16;
  localparam int DEF_SMPL_CNT      = 4;
  localparam bit DEF_RST_VAL       = 1'b0;

  // Counter holds 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [cnt_width(DEF_SMPL_CNT)-1:0] chan_cnt_t;

endpackage

// File: rtl/sig_deb_bank_if.sv
// Pin-side bundle of the debouncer bank: raw inputs plus conditioned levels/strobes.
// Optional edge strobes are enabled by defining SIG_DEB_EDGE_EN.
interface sig_deb_bank_if
  import sig_deb_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS
);

  // Plain level signals, no valid/ready handshake: i_sig is sampled every clk,
  // o_sig is a held level, o_rise/o_fall/o_chg are single-cycle strobes.
  logic [CHANNELS-1:0] i_sig;
  logic [CHANNELS-1:0] o_sig;
  logic [CHANNELS-1:0] o_rise;
  logic [CHANNELS-1:0] o_fall;
  logic                o_chg;

  modport master (output i_sig, input o_sig, input o_rise, input o_fall, input o_chg);
  modport slave  (input i_sig, output o_sig, output o_rise, output o_fall, output o_chg);

endinterface

// File: rtl/sig_deb_chan.sv
// One debounce channel: 2-flop synchroniser, sample-tick counter, output level and strobes.
// Edge strobe registers are built only when SIG_DEB_EDGE_EN is defined.
module sig_deb_chan
  import sig_deb_pkg::*;
#(
  parameter int SMPL_CNT = DEF_SMPL_CNT,
  parameter bit RST_VAL  = DEF_RST_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic din,
  output logic sig,
  output logic rise,
  output logic fall
`ifdef SIG_DEB_EDGE_EN
  ,
  output logic flip
`endif
);

  localparam int              CNT_W   = cnt_width(SMPL_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SMPL_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             sig_s;

  assign sig_s = sync[1];

  // Any agreeing cycle clears the count, so only an unbroken run of
  // SMPL_CNT disagreeing ticks can move the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {2{RST_VAL}};
      cnt  <= '0;
      sig  <= RST_VAL;
    end else begin
      sync <= {sync[0], din};
      if (sig_s == sig) begin
        cnt <= '0;
      end else if (tck && (cnt == CNT_MAX)) begin
        sig <= sig_s;
        cnt <= '0;
      end else if (tck) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

`ifdef SIG_DEB_EDGE_EN
  assign flip = (sig_s != sig) && tck && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip && sig_s;
      fall <= flip && !sig_s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sig_deb_bank.sv
// Multi-channel symmetric debouncer sharing one sample-tick prescaler.
// Define SIG_DEB_EDGE_EN to build the o_rise/o_fall/o_chg strobes; otherwise they read 0.
module sig_deb_bank
  import sig_deb_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int CLKS_PER_SMPL = DEF_CLKS_PER_SMPL,
  parameter int SMPL_CNT      = DEF_SMPL_CNT,
  parameter bit RST_VAL       = DEF_RST_VAL
) (
  input logic           clk,
  input logic           rst_n,
  sig_deb_bank_if.slave bus
);

  localparam logic [CLKS_PER_SMPL-1:0] PRESC_ONE = CLKS_PER_SMPL'(1);

  logic [CLKS_PER_SMPL-1:0] presc;
  logic                     tck;
  logic [CHANNELS-1:0]      sig;
  logic [CHANNELS-1:0]      rise;
  logic [CHANNELS-1:0]      fall;

  // Free-running; input activity never restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + PRESC_ONE;
  end

  assign tck = &presc;

`ifdef SIG_DEB_EDGE_EN
  logic [CHANNELS-1:0] flip;
  logic                chg;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    sig_deb_chan #(
      .SMPL_CNT (SMPL_CNT),
      .RST_VAL  (RST_VAL)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .tck   (tck),
      .din   (bus.i_sig[k]),
      .sig   (sig[k]),
      .rise  (rise[k]),
      .fall  (fall[k])
`ifdef SIG_DEB_EDGE_EN
      ,
      .flip  (flip[k])
`endif
    );
  end

`ifdef SIG_DEB_EDGE_EN
  // Registered from the same pre-edge condition as the strobes so it lines up with them.
  always_ff @(posedge clk) begin
    if (!rst_n) chg <= 1'b0;
    else        chg <= |flip;
  end
  assign bus.o_chg = chg;
`else
  assign bus.o_chg = 1'b0;
`endif

  assign bus.o_sig  = sig;
  assign bus.o_rise = rise;
  assign bus.o_fall = fall;

endmodule

// File: tb/tb_sig_deb_bank.sv
// Bench for sig_deb_bank: directed scenarios plus random holds against a sample-run reference model.
// Strobe expectations follow whether SIG_DEB_EDGE_EN is defined for the build.
module tb_sig_deb_bank;
  import sig_deb_pkg::*;

  localparam int CH       = 4;
  localparam int CPS      = 2;
  localparam int SC       = 3;
  localparam bit RV       = 1'b0;
  localparam int TICK_LEN = 1 << CPS;
  localparam int W        = 3 * CH + 1;
`ifdef SIG_DEB_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sig_deb_bank_if #(.CHANNELS(CH)) bus ();

  sig_deb_bank #(
    .CHANNELS      (CH),
    .CLKS_PER_SMPL (CPS),
    .SMPL_CNT      (SC),
    .RST_VAL       (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks clocks since reset release, the input as seen two clocks late,
  // and per channel how many ticks have elapsed in the current disagreeing run.
  logic [W-1:0]    exp_q[$];
  int              phase;
  int              run[CH];
  logic [CH-1:0]   h1, h2, m_sig, m_rise, m_fall;
  logic            m_chg;

  always @(posedge clk) begin : ref_model
    logic [CH-1:0] nr, nf;
    bit tick;
    if (!rst_n) begin
      phase  = 0;
      h1     = {CH{RV}};
      h2     = {CH{RV}};
      m_sig  = {CH{RV}};
      m_rise = '0;
      m_fall = '0;
      m_chg  = 1'b0;
      foreach (run[k]) run[k] = 0;
    end else begin
      tick  = (phase % TICK_LEN) == (TICK_LEN - 1);
      phase = phase + 1;
      nr = '0;
      nf = '0;
      for (int k = 0; k < CH; k++) begin
        if (h2[k] == m_sig[k]) begin
          run[k] = 0;
        end else if (tick) begin
          run[k] = run[k] + 1;
          if (run[k] == SC) begin
            run[k]   = 0;
            m_sig[k] = h2[k];
            nr[k]    = h2[k];
            nf[k]    = ~h2[k];
          end
        end
      end
      h2     = h1;
      h1     = bus.i_sig;
      m_rise = EDGE_EN ? nr : '0;
      m_fall = EDGE_EN ? nf : '0;
      m_chg  = EDGE_EN && (|(nr | nf));
    end
    exp_q.push_back({m_sig, m_rise, m_fall, m_chg});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got sig/rise/fall/chg=%h expected %h", $time, a, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [CH-1:0] v, input int n);
    bus.i_sig = v;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int seen, rises, rise_at;
    rst_n = 1'b0;
    bus.i_sig = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %h%h%h%b expected all 0", i, bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg);
      end
    end
    rst_n = 1'b1;
    seen = -1; rises = 0; rise_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (seen < 0 && bus.o_sig === 4'hF) seen = i;
      if (bus.o_rise !== 4'h0) begin
        rises++;
        rise_at = i;
        checks++;
        if (bus.o_rise !== 4'hF || bus.o_chg !== 1'b1) begin
          errors++;
          $display("FAIL reset_rise_shape got rise=%h chg=%b expected rise=f chg=1", bus.o_rise, bus.o_chg);
        end
      end
    end
    checks++;
    if (seen != 11) begin
      errors++;
      $display("FAIL reset_latency got %0d expected 11", seen);
    end
    checks++;
    if (rises != (EDGE_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL reset_rise_count got %0d expected %0d", rises, EDGE_EN ? 1 : 0);
    end
    if (EDGE_EN) begin
      checks++;
      if (rise_at != seen) begin
        errors++;
        $display("FAIL reset_rise_align got %0d expected %0d", rise_at, seen);
      end
    end
  endtask

  task automatic test_glitch();
    drive(4'h0, 20);
    for (int i = 0; i < 25; i++) begin
      bus.i_sig = (i < 5) ? 4'h1 : 4'h0;
      @(negedge clk);
      checks++;
      if (bus.o_sig[0] !== 1'b0 || bus.o_rise !== 4'h0 || bus.o_fall !== 4'h0 || bus.o_chg !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc=%0d got sig=%h rise=%h fall=%h chg=%b expected sig0=0 and no strobes",
                 i, bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg);
      end
    end
  endtask

  task automatic test_release();
    int fell_at, falls, fall_at;
    drive(4'h5, 25);
    checks++;
    if (bus.o_sig !== 4'h5) begin
      errors++;
      $display("FAIL release_setup got %h expected 5", bus.o_sig);
    end
    bus.i_sig = 4'h1;
    fell_at = -1; falls = 0; fall_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fell_at < 0 && bus.o_sig[2] === 1'b0) fell_at = i;
      if (bus.o_fall[2] === 1'b1) begin falls++; fall_at = i; end
      checks++;
      if (bus.o_sig[0] !== 1'b1 || bus.o_sig[1] !== 1'b0 || bus.o_sig[3] !== 1'b0 ||
          bus.o_rise !== 4'h0 || (bus.o_fall & 4'hB) !== 4'h0) begin
        errors++;
        $display("FAIL release_others cyc=%0d got sig=%h rise=%h fall=%h expected other channels quiet",
                 i, bus.o_sig, bus.o_rise, bus.o_fall);
      end
    end
    checks++;
    if (fell_at < 2 + (SC - 1) * TICK_LEN || fell_at > 2 + (SC - 1) * TICK_LEN + TICK_LEN - 1) begin
      errors++;
      $display("FAIL release_latency got %0d expected 10..13", fell_at);
    end
    checks++;
    if (falls != (EDGE_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL release_fall_count got %0d expected %0d", falls, EDGE_EN ? 1 : 0);
    end
    if (EDGE_EN) begin
      checks++;
      if (fall_at != fell_at) begin
        errors++;
        $display("FAIL release_fall_align got %0d expected %0d", fall_at, fell_at);
      end
    end
  endtask

  task automatic test_simultaneous();
    int rise_at, fall_at, chg_cnt;
    drive(4'h8, 25);
    bus.i_sig = 4'h2;
    rise_at = -1; fall_at = -1; chg_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_rise[1] === 1'b1) rise_at = i;
      if (bus.o_fall[3] === 1'b1) fall_at = i;
      if (bus.o_chg === 1'b1) chg_cnt++;
    end
    checks++;
    if (bus.o_sig !== 4'h2) begin
      errors++;
      $display("FAIL simul_level got %h expected 2", bus.o_sig);
    end
    checks++;
    if (chg_cnt != (EDGE_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL simul_chg_count got %0d expected %0d", chg_cnt, EDGE_EN ? 1 : 0);
    end
    checks++;
    if (EDGE_EN ? (rise_at < 0 || rise_at != fall_at) : (rise_at >= 0 || fall_at >= 0)) begin
      errors++;
      $display("FAIL simul_align got rise_at=%0d fall_at=%0d expected equal (or none without strobes)", rise_at, fall_at);
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    drive(4'h0, 25);
    drive(4'h1, 10);
    checks++;
    if (bus.o_sig[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre got %b expected 0", bus.o_sig[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg} !== '0) begin
      errors++;
      $display("FAIL midrst_during got %h%h%h%b expected all 0", bus.o_sig, bus.o_rise, bus.o_fall, bus.o_chg);
    end
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.o_rise[0] === 1'b1) rises++;
      checks++;
      if (bus.o_sig[0] !== (i >= 11)) begin
        errors++;
        $display("FAIL midrst_recount cyc=%0d got %b expected %b", i, bus.o_sig[0], i >= 11);
      end
    end
    checks++;
    if (rises != (EDGE_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL midrst_rise_count got %0d expected %0d", rises, EDGE_EN ? 1 : 0);
    end
  endtask

  task automatic test_chatter();
    int rises, falls;
    drive(4'h0, 25);
    rises = 0; falls = 0;
    for (int i = 0; i < 40; i++) begin
      bus.i_sig[0] = ((i / 3) % 2) == 0;
      @(negedge clk);
      if (bus.o_rise[0] === 1'b1) rises++;
      if (bus.o_fall[0] === 1'b1) falls++;
      checks++;
      if (bus.o_sig[0] !== 1'b0) begin
        errors++;
        $display("FAIL chatter_level cyc=%0d got %b expected 0", i, bus.o_sig[0]);
      end
    end
    bus.i_sig[0] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.o_rise[0] === 1'b1) rises++;
      if (bus.o_fall[0] === 1'b1) falls++;
    end
    checks++;
    if (bus.o_sig[0] !== 1'b1) begin
      errors++;
      $display("FAIL chatter_final got %b expected 1", bus.o_sig[0]);
    end
    checks++;
    if (rises != (EDGE_EN ? 1 : 0) || falls != 0) begin
      errors++;
      $display("FAIL chatter_strobes got rises=%0d falls=%0d expected %0d and 0", rises, falls, EDGE_EN ? 1 : 0);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] v;
    int n;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      v = CH'($urandom_range(0, 15));
      n = $urandom_range(1, 24);
      drive(v, n);
      if (n >= 16) begin
        checks++;
        if (bus.o_sig !== v) begin
          errors++;
          $display("FAIL random_settle t=%0d got %h expected %h", t, bus.o_sig, v);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.i_sig = '0;
    test_reset();
    test_glitch();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_chatter();
    test_random();
    drive(bus.i_sig, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
